// File: rtl/conv_multadd_ctrl_if.sv
// Handshake/bus bundle between the conv multiply-add sequencer and its
// surroundings: run control, weight-buffer read port, array tags and output qualifiers.
interface conv_multadd_ctrl_if;
  logic       start;
  logic       abort;
  logic       stall;
  logic       w_rd;
  logic [8:0] w_addr;
  logic       en;
  logic [4:0] cnt;
  logic [3:0] pos;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;

  modport master (
    input  start, abort, stall,
    output w_rd, w_addr, en, cnt, pos, out_valid, out_last, busy, done
  );

  modport slave (
    output start, abort, stall,
    input  w_rd, w_addr, en, cnt, pos, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/conv_multadd_ctrl.sv
// Sequencer for the 16-lane conv multiply-add array: walks pos x cnt steps,
// fetching each weight slice before firing en, and tracks the array pipeline.
module conv_multadd_ctrl #(
  parameter int CNT_MAX  = 31,
  parameter int POS_MAX  = 8,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  conv_multadd_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, FIRE, DRAIN, DONE} state_e;

  localparam int TMR_MAX = (RD_LAT > PIPE_LAT) ? RD_LAT : PIPE_LAT;
  localparam int TW      = $clog2(TMR_MAX + 1);

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [3:0]          pos_q, pos_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [PIPE_LAT:1]   vld_pipe_q, vld_pipe_d;
  logic [PIPE_LAT:1]   lst_pipe_q, lst_pipe_d;

  logic busy, kill, fire, last_step;

  assign busy      = (state_q != IDLE);
  assign kill      = bus.abort && busy;
  // abort beats stall, so a fire can never slip out in the abort cycle
  assign fire      = (state_q == FIRE) && !bus.stall && !bus.abort;
  assign last_step = (cnt_q == 5'(CNT_MAX)) && (pos_q == 4'(POS_MAX));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    tmr_d      = '0;
    vld_pipe_d = vld_pipe_q;
    lst_pipe_d = lst_pipe_q;
    vld_pipe_d[1] = fire;
    lst_pipe_d[1] = fire && last_step;
    for (int i = 2; i <= PIPE_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      lst_pipe_d[i] = lst_pipe_q[i-1];
    end

    case (state_q)
      IDLE: if (bus.start && !bus.abort) begin
        state_d = FETCH;
        cnt_d   = '0;
        pos_d   = '0;
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (tmr_q == TW'(RD_LAT - 1)) state_d = FIRE;
        else                          tmr_d   = tmr_q + 1'b1;
      end
      FIRE: if (!bus.stall) begin
        state_d = FETCH;
        if (cnt_q < 5'(CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (pos_q < 4'(POS_MAX)) begin
          cnt_d = '0;
          pos_d = pos_q + 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tmr_q == TW'(PIPE_LAT - 1)) state_d = DONE;
        else                            tmr_d   = tmr_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        pos_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    if (kill) begin
      state_d    = IDLE;
      cnt_d      = '0;
      pos_d      = '0;
      tmr_d      = '0;
      vld_pipe_d = '0;
      lst_pipe_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pos_q      <= '0;
      tmr_q      <= '0;
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      tmr_q      <= tmr_d;
      vld_pipe_q <= vld_pipe_d;
      lst_pipe_q <= lst_pipe_d;
    end
  end

  assign bus.w_rd      = (state_q == FETCH) && !bus.abort;
  assign bus.w_addr    = {pos_q, cnt_q};
  assign bus.en        = fire;
  assign bus.cnt       = cnt_q;
  assign bus.pos       = pos_q;
  assign bus.out_valid = vld_pipe_q[PIPE_LAT];
  assign bus.out_last  = lst_pipe_q[PIPE_LAT];
  assign bus.busy      = busy;
  assign bus.done      = (state_q == DONE) && !bus.abort;

endmodule

// File: tb/tb_conv_multadd_ctrl.sv
// Directed bench: default-parameter sequencer checked against a queue
// scoreboard of expected fetch/fire/output events; small-parameter copy checked per cycle.
module tb_conv_multadd_ctrl;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  conv_multadd_ctrl_if ia ();
  conv_multadd_ctrl_if ib ();

  conv_multadd_ctrl dut_a (.clk(clk), .rst_b(rst_b), .bus(ia.master));
  conv_multadd_ctrl #(.CNT_MAX(3), .POS_MAX(1), .RD_LAT(3), .PIPE_LAT(4))
    dut_b (.clk(clk), .rst_b(rst_b), .bus(ib.master));

  typedef struct { int cyc; int pos; int cnt; bit last; } ev_t;

  ev_t q_en[$], q_rd[$], q_ov[$];
  int  cyc = 0, S = 0, Sb = 0;
  int  vec = 0, errs = 0;
  int  exp_done = -1, n_done = 0;
  bit  mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // expected events of one run; cut = first cycle where en/w_rd/done vanish,
  // ov_cut = first cycle where out_valid vanishes
  task automatic push_run(input int stall_step, input int stall_len,
                          input int cut, input int ov_cut, input bit with_done);
    int fire, rd;
    q_en.delete(); q_rd.delete(); q_ov.delete();
    for (int n = 0; n < 288; n++) begin
      fire = 3 + 3*n + ((n >= stall_step) ? stall_len : 0);
      rd   = fire - 2 - ((n == stall_step) ? stall_len : 0);
      if (rd < cut)       q_rd.push_back('{rd, n/32, n%32, 1'b0});
      if (fire < cut)     q_en.push_back('{fire, n/32, n%32, n == 287});
      if (fire + 2 < ov_cut) q_ov.push_back('{fire + 2, n/32, n%32, n == 287});
    end
    exp_done = with_done ? 867 + stall_len : -1;
    n_done   = 0;
  endtask

  always @(negedge clk) if (mon_on) begin
    ev_t e;
    int  rel;
    rel = cyc - S;
    if (ia.w_rd) begin
      if (q_rd.size() == 0) chk("rd_unexpected", ia.w_rd, 0);
      else begin
        e = q_rd.pop_front();
        chk("rd_cycle", rel, e.cyc);
        chk("rd_addr", ia.w_addr, e.pos*32 + e.cnt);
      end
    end
    if (ia.en) begin
      if (q_en.size() == 0) chk("en_unexpected", ia.en, 0);
      else begin
        e = q_en.pop_front();
        chk("en_cycle", rel, e.cyc);
        chk("en_pos", ia.pos, e.pos);
        chk("en_cnt", ia.cnt, e.cnt);
        chk("en_addr", ia.w_addr, e.pos*32 + e.cnt);
      end
    end
    if (ia.out_valid) begin
      if (q_ov.size() == 0) chk("ov_unexpected", ia.out_valid, 0);
      else begin
        e = q_ov.pop_front();
        chk("ov_cycle", rel, e.cyc);
        chk("ov_last", ia.out_last, e.last);
      end
    end else if (ia.out_last) chk("last_without_valid", ia.out_last, 0);
    if (ia.done) begin
      n_done++;
      chk("done_cycle", rel, exp_done);
    end
  end

  // advance to #1 into run-relative cycle k (k must lie ahead)
  task automatic at_cyc(input int k);
    while (cyc - S != k) begin @(posedge clk); #1; end
  endtask

  task automatic start_run();
    ia.start = 1'b1;
    @(posedge clk); #1;
    S = cyc - 1;
    ia.start = 1'b0;
    chk("busy_c1", ia.busy, 1);
  endtask

  task automatic run_full(input int stall_step, input int stall_len, input bit restart);
    push_run(stall_step, stall_len, 1 << 30, 1 << 30, 1'b1);
    start_run();
    if (stall_len > 0) begin
      at_cyc(3 + 3*stall_step);
      ia.stall = 1'b1;
      at_cyc(4 + 3*stall_step);
      chk("stall_en", ia.en, 0);
      chk("stall_cnt", ia.cnt, stall_step);
      chk("stall_addr", ia.w_addr, stall_step);
      at_cyc(3 + 3*stall_step + stall_len);
      ia.stall = 1'b0;
    end
    if (restart) begin
      at_cyc(10);  ia.start = 1'b1;
      at_cyc(11);  ia.start = 1'b0;
      at_cyc(400); ia.start = 1'b1;
      at_cyc(401); ia.start = 1'b0;
    end
    at_cyc(867 + stall_len);
    chk("busy_end", ia.busy, 1);
    at_cyc(868 + stall_len);
    chk("busy_after", ia.busy, 0);
    chk("queues_left", q_en.size() + q_rd.size() + q_ov.size(), 0);
    chk("done_count", n_done, 1);
  endtask

  initial begin
    logic [4:0] bx, bexp;
    ia.start = 0; ia.abort = 0; ia.stall = 0;
    ib.start = 0; ib.abort = 0; ib.stall = 0;
    repeat (3) @(posedge clk); #1;
    chk("reset_a", {ia.w_rd, ia.w_addr, ia.en, ia.cnt, ia.pos, ia.out_valid,
                    ia.out_last, ia.busy, ia.done}, 0);
    chk("reset_b", {ib.w_rd, ib.en, ib.out_valid, ib.out_last, ib.busy, ib.done}, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;

    run_full(1000, 0, 1'b0);
    run_full(5, 4, 1'b0);

    push_run(1000, 0, 100, 101, 1'b0);
    start_run();
    at_cyc(100); ia.abort = 1'b1;
    at_cyc(101); ia.abort = 1'b0;
    chk("abort_busy", ia.busy, 0);
    at_cyc(900);
    chk("abort_queues", q_en.size() + q_rd.size() + q_ov.size(), 0);
    chk("abort_done", n_done, 0);
    run_full(1000, 0, 1'b0);

    push_run(1000, 0, 500, 500, 1'b0);
    start_run();
    at_cyc(500); rst_b = 1'b0; #1;
    chk("midrun_reset", {ia.w_rd, ia.w_addr, ia.en, ia.cnt, ia.pos, ia.out_valid,
                         ia.out_last, ia.busy, ia.done}, 0);
    chk("reset_queues", q_en.size() + q_rd.size() + q_ov.size(), 0);
    repeat (3) @(posedge clk); #1;
    rst_b = 1'b1;
    run_full(1000, 0, 1'b1);

    ib.start = 1'b1;
    @(posedge clk); #1;
    Sb = cyc - 1;
    ib.start = 1'b0;
    for (int k = 1; k <= 47; k++) begin
      bexp[4] = (k % 5 == 0) && (k >= 5) && (k <= 40);
      bexp[3] = (k % 5 == 1) && (k <= 36);
      bexp[2] = (k >= 9) && (k <= 44) && ((k - 4) % 5 == 0);
      bexp[1] = (k == 44);
      bexp[0] = (k == 45);
      bx = {ib.en, ib.w_rd, ib.out_valid, ib.out_last, ib.done};
      chk("small_ctl", bx, bexp);
      chk("small_busy", ib.busy, k <= 45);
      if (bexp[4]) begin
        chk("small_cnt", ib.cnt, ((k/5) - 1) % 4);
        chk("small_pos", ib.pos, ((k/5) - 1) / 4);
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
